// File: rtl/video_out_pkg.sv
// ----------------------------------------------------------------------------
// video_out_pkg
// Shared types and constants for the OLED-to-RGB output stage.
//   rgb_t           : {r, g, b}, 8 bits per channel, r in the MSBs
//   palette_entry_t : {off, on} colour pair for one palette
//   PALETTE         : the eight fixed two-colour palettes
//   PIXEL_SCALE     : output pixels per OLED pixel on each axis
//   dim_rgb()       : pixel-gap dimming, c - (c >> 2) per channel
// ----------------------------------------------------------------------------
package video_out_pkg;

    localparam int PIXEL_SCALE = 6;
    localparam int PHASE_W     = $clog2(PIXEL_SCALE);
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(PIXEL_SCALE - 1);

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        rgb_t off;
        rgb_t on;
    } palette_entry_t;

    localparam palette_entry_t PALETTE [8] = '{
        '{off: 24'h000000, on: 24'hFFFFFF},
        '{off: 24'hFFFFFF, on: 24'h000000},
        '{off: 24'h0F380F, on: 24'h9BBC0F},
        '{off: 24'h000000, on: 24'hFFB000},
        '{off: 24'h000000, on: 24'h33FF33},
        '{off: 24'h10102A, on: 24'hA0C8FF},
        '{off: 24'h2A0000, on: 24'hFF4040},
        '{off: 24'h202020, on: 24'hE0E0E0}
    };

    // Removes a quarter of each channel; the result is never larger than the
    // input, so 8 bits always suffice.
    function automatic rgb_t dim_rgb(input rgb_t c);
        rgb_t d;
        d.r = c.r - (c.r >> 2);
        d.g = c.g - (c.g >> 2);
        d.b = c.b - (c.b >> 2);
        return d;
    endfunction

endpackage

// File: rtl/pixel_phase_counter.sv
// ----------------------------------------------------------------------------
// pixel_phase_counter
// Modulo-MOD phase counter with a load port and a step strobe. Used once for
// the column phase and once for the row phase of the pixel-grid lattice.
//   i_clk, i_reset : clock, synchronous active-high reset (to RESET_VAL)
//   i_load_val     : value taken when i_load=1
//   i_load         : load strobe, has priority over i_step
//   i_step         : advance by one, wrapping MOD-1 -> 0
//   o_phase        : phase that applies to the current cycle, i.e. the value
//                    the register takes at the coming edge
// ----------------------------------------------------------------------------
module pixel_phase_counter
    import video_out_pkg::*;
#(
    parameter int               MOD       = PIXEL_SCALE,
    parameter int               WIDTH     = PHASE_W,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_load,
    input  logic             i_step,
    output logic [WIDTH-1:0] o_phase
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] r_phase;
    logic [WIDTH-1:0] w_phase_next;

    always_comb begin
        w_phase_next = r_phase;
        if (i_load) begin
            w_phase_next = i_load_val;
        end else if (i_step) begin
            w_phase_next = (r_phase == LAST) ? '0 : r_phase + WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_phase <= RESET_VAL;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    // The pixel seen in a cycle uses the phase loaded/stepped in that cycle,
    // so the first pixel of a line already carries the start phase.
    assign o_phase = w_phase_next;

endmodule

// File: rtl/video_rgb_out.sv
// ----------------------------------------------------------------------------
// video_rgb_out
// Converts the 1-bit OLED raster into 24-bit RGB: palette lookup, optional
// pixel-gap grid dimming, blanking, and 2-cycle delayed sync/enable strobes.
//   clk_pixel, reset : pixel clock, synchronous active-high reset
//   v_sync, h_sync   : one-cycle frame / line sync pulses
//   video_en, video  : active-region enable and OLED pixel value
//   palette_sel      : palette index, latched when v_sync=1
//   grid_en          : grid dimming enable, latched when v_sync=1
//   vid_rgb          : {R,G,B}, zero whenever vid_de=0
//   vid_vs/hs/de     : inputs delayed by exactly 2 cycles
// Interface: streaming, no backpressure. vid_de qualifies vid_rgb: a pixel
// is valid exactly on cycles with vid_de=1; there is no ready.
// ----------------------------------------------------------------------------
module video_rgb_out
    import video_out_pkg::*;
#(
    parameter int H_START_PHASE = 2,
    parameter int V_START_PHASE = 0
) (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic        v_sync,
    input  logic        h_sync,
    input  logic        video_en,
    input  logic        video,
    input  logic [2:0]  palette_sel,
    input  logic        grid_en,
    output logic [23:0] vid_rgb,
    output logic        vid_vs,
    output logic        vid_hs,
    output logic        vid_de
);

    // Frame-boundary configuration and edge detection
    logic [2:0]         r_pal_active;
    logic               r_grid_active;
    logic               r_en_prev;

    // Stage 1
    logic               r_s1_lit;
    logic               r_s1_grid;
    logic [2:0]         r_s1_pal;
    logic               r_s1_vs;
    logic               r_s1_hs;
    logic               r_s1_de;

    logic               w_en_rise;
    logic               w_en_fall;
    logic [PHASE_W-1:0] w_col_phase;
    logic [PHASE_W-1:0] w_row_phase;
    logic [2:0]         w_pal_now;
    logic               w_grid_now;
    logic               w_grid_pix;
    rgb_t               w_base;
    rgb_t               w_pix;

    assign w_en_rise = video_en & ~r_en_prev;
    assign w_en_fall = ~video_en & r_en_prev;

    pixel_phase_counter #(
        .MOD       (PIXEL_SCALE),
        .WIDTH     (PHASE_W),
        .RESET_VAL ('0)
    ) u_col_phase (
        .i_clk      (clk_pixel),
        .i_reset    (reset),
        .i_load_val (PHASE_W'(H_START_PHASE)),
        .i_load     (w_en_rise),
        .i_step     (video_en),
        .o_phase    (w_col_phase)
    );

    // v_sync is the load and wins over a coincident falling edge.
    pixel_phase_counter #(
        .MOD       (PIXEL_SCALE),
        .WIDTH     (PHASE_W),
        .RESET_VAL (PHASE_W'(V_START_PHASE))
    ) u_row_phase (
        .i_clk      (clk_pixel),
        .i_reset    (reset),
        .i_load_val (PHASE_W'(V_START_PHASE)),
        .i_load     (v_sync),
        .i_step     (w_en_fall),
        .o_phase    (w_row_phase)
    );

    // Settings latched on v_sync apply from that same cycle onward, so the
    // frame that follows the sync is never split between two palettes.
    always_comb begin
        w_pal_now  = r_pal_active;
        w_grid_now = r_grid_active;
        if (v_sync) begin
            w_pal_now  = palette_sel;
            w_grid_now = grid_en;
        end
    end

    assign w_grid_pix = w_grid_now &
                        ((w_col_phase == LAST_PHASE) | (w_row_phase == LAST_PHASE));

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_pal_active  <= '0;
            r_grid_active <= 1'b0;
            r_en_prev     <= 1'b0;
            r_s1_lit      <= 1'b0;
            r_s1_grid     <= 1'b0;
            r_s1_pal      <= '0;
            r_s1_vs       <= 1'b0;
            r_s1_hs       <= 1'b0;
            r_s1_de       <= 1'b0;
        end else begin
            r_pal_active  <= w_pal_now;
            r_grid_active <= w_grid_now;
            r_en_prev     <= video_en;
            r_s1_lit      <= video;
            r_s1_grid     <= w_grid_pix;
            r_s1_pal      <= w_pal_now;
            r_s1_vs       <= v_sync;
            r_s1_hs       <= h_sync;
            r_s1_de       <= video_en;
        end
    end

    // Stage 2: lookup, dimming, blanking
    always_comb begin
        w_base = r_s1_lit ? PALETTE[r_s1_pal].on : PALETTE[r_s1_pal].off;
        w_pix  = r_s1_grid ? dim_rgb(w_base) : w_base;
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            vid_rgb <= '0;
            vid_vs  <= 1'b0;
            vid_hs  <= 1'b0;
            vid_de  <= 1'b0;
        end else begin
            vid_rgb <= r_s1_de ? w_pix : '0;
            vid_vs  <= r_s1_vs;
            vid_hs  <= r_s1_hs;
            vid_de  <= r_s1_de;
        end
    end

endmodule

// File: tb/tb_video_rgb_out.sv
// ----------------------------------------------------------------------------
// tb_video_rgb_out
// Drives raster sequences into video_rgb_out. A reference model computes the
// expected output of every cycle from pixel/line counts and pushes it into a
// queue; a monitor pops and compares against the DUT outputs.
// ----------------------------------------------------------------------------
module tb_video_rgb_out;

    localparam int H_START = 2;
    localparam int V_START = 0;
    localparam int SCALE   = 6;

    logic        clk_pixel = 1'b0;
    logic        reset     = 1'b1;
    logic        v_sync    = 1'b0;
    logic        h_sync    = 1'b0;
    logic        video_en  = 1'b0;
    logic        video     = 1'b0;
    logic [2:0]  palette_sel = '0;
    logic        grid_en   = 1'b0;
    logic [23:0] vid_rgb;
    logic        vid_vs;
    logic        vid_hs;
    logic        vid_de;

    int          errors = 0;
    int          checks = 0;
    int          n_pops = 0;
    int          cycle  = 0;
    string       cur_test = "reset";
    logic [2:0]  cur_sel  = '0;
    logic        cur_grid = 1'b0;

    logic [26:0] exp_q[$];

    logic [23:0] pal_off [8] = '{24'h000000, 24'hFFFFFF, 24'h0F380F, 24'h000000,
                                 24'h000000, 24'h10102A, 24'h2A0000, 24'h202020};
    logic [23:0] pal_on  [8] = '{24'hFFFFFF, 24'h000000, 24'h9BBC0F, 24'hFFB000,
                                 24'h33FF33, 24'hA0C8FF, 24'hFF4040, 24'hE0E0E0};

    video_rgb_out #(
        .H_START_PHASE (H_START),
        .V_START_PHASE (V_START)
    ) dut (
        .clk_pixel   (clk_pixel),
        .reset       (reset),
        .v_sync      (v_sync),
        .h_sync      (h_sync),
        .video_en    (video_en),
        .video       (video),
        .palette_sel (palette_sel),
        .grid_en     (grid_en),
        .vid_rgb     (vid_rgb),
        .vid_vs      (vid_vs),
        .vid_hs      (vid_hs),
        .vid_de      (vid_de)
    );

    // ---------------- clock ----------------
    always #5 clk_pixel = ~clk_pixel;

    always @(posedge clk_pixel) cycle++;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete (got no finish, required finish)");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] dim8(input logic [7:0] c);
        return c - c / 4;
    endfunction

    function automatic logic [23:0] dim24(input logic [23:0] p);
        return {dim8(p[23:16]), dim8(p[15:8]), dim8(p[7:0])};
    endfunction

    bit          m_prev_en = 1'b0;
    int          m_pix_idx = 0;   // active pixels since the start of the line
    int          m_line_cnt = 0;  // lines ended since the last v_sync
    int          m_pal = 0;
    bit          m_grid = 1'b0;
    int          m_col;
    int          m_row;
    bit          m_gpix;
    logic [23:0] m_base;
    logic [23:0] m_rgb;

    always @(posedge clk_pixel) begin
        if (reset) begin
            // Anything in flight is lost; the next two outputs are zero.
            exp_q.delete();
            exp_q.push_back('0);
            exp_q.push_back('0);
            m_prev_en  = 1'b0;
            m_pix_idx  = 0;
            m_line_cnt = 0;
            m_pal      = 0;
            m_grid     = 1'b0;
        end else begin
            if (video_en && !m_prev_en) m_pix_idx = 0;
            else if (video_en)          m_pix_idx = m_pix_idx + 1;
            if (v_sync)                       m_line_cnt = 0;
            else if (!video_en && m_prev_en)  m_line_cnt = m_line_cnt + 1;
            if (v_sync) begin
                m_pal  = int'(palette_sel);
                m_grid = grid_en;
            end
            m_col  = (H_START + m_pix_idx) % SCALE;
            m_row  = (V_START + m_line_cnt) % SCALE;
            m_gpix = m_grid && (m_col == SCALE - 1 || m_row == SCALE - 1);
            m_base = video ? pal_on[m_pal] : pal_off[m_pal];
            m_rgb  = !video_en ? 24'h0 : (m_gpix ? dim24(m_base) : m_base);
            exp_q.push_back({m_rgb, v_sync, h_sync, video_en});
            m_prev_en = video_en;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%s] cycle %0d: got %06h expected %06h",
                     name, cur_test, cycle, act, exp);
        end
    endtask

    logic [26:0] e;
    always @(posedge clk_pixel) begin
        #1;
        if (exp_q.size() > 1) begin
            e = exp_q.pop_front();
            n_pops++;
            check("vid_rgb", 32'(vid_rgb), 32'(e[26:3]));
            check("vid_vs",  32'(vid_vs),  32'(e[2]));
            check("vid_hs",  32'(vid_hs),  32'(e[1]));
            check("vid_de",  32'(vid_de),  32'(e[0]));
            if (!vid_de) check("blank", 32'(vid_rgb), 32'h0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic vs, input logic hs, input logic en, input logic vid);
        @(negedge clk_pixel);
        v_sync      = vs;
        h_sync      = hs;
        video_en    = en;
        video       = vid;
        palette_sel = cur_sel;
        grid_en     = cur_grid;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic vsync();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // mode 0: all lit, 1: alternating starting lit, 2: random
    task automatic line_body(input int npix, input int mode);
        logic v;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);
        for (int i = 0; i < npix; i++) begin
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = (i % 2 == 0);
            else                v = 1'($urandom_range(0, 1));
            drive(1'b0, 1'b0, 1'b1, v);
        end
    endtask

    task automatic line(input int npix, input int mode);
        line_body(npix, mode);
        idle(2);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic en_r;

        // power-on reset
        idle(3);
        @(negedge clk_pixel) reset = 1'b0;
        idle(3);

        // reset held 3 cycles in the middle of a lit line
        cur_test = "midline_reset";
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        repeat (5) drive(1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk_pixel) reset = 1'b1;
        repeat (2) @(negedge clk_pixel);
        @(negedge clk_pixel) reset = 1'b0;
        repeat (10) drive(1'b0, 1'b0, 1'b1, 1'b1);
        idle(3);

        // palette request without v_sync is ignored, then taken at v_sync
        cur_test = "palette_no_vsync";
        cur_sel = 3'd2;
        line(20, 1);
        cur_test = "palette_after_vsync";
        vsync();
        line(20, 1);
        line(20, 1);

        // request changes the cycle after v_sync: frame stays on palette 3
        cur_test = "palette_late_change";
        cur_sel = 3'd3;
        vsync();
        cur_sel = 3'd4;
        line(30, 0);
        line(30, 1);

        // grid lattice over full-width lines, palette 0
        cur_test = "grid_800";
        cur_sel  = 3'd0;
        cur_grid = 1'b1;
        vsync();
        cur_grid = 1'b0;
        for (int l = 0; l < 7; l++) line(800, 0);

        // line ends exactly on the v_sync cycle: row phase must restart
        cur_test = "vsync_on_fall";
        cur_grid = 1'b1;
        cur_sel  = 3'd7;
        vsync();
        line_body(40, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int l = 0; l < 7; l++) line(30, 2);

        // random strobes and configuration across two frames
        cur_test = "random";
        en_r = 1'b0;
        for (int f = 0; f < 2; f++) begin
            cur_sel  = 3'($urandom_range(0, 7));
            cur_grid = 1'($urandom_range(0, 1));
            vsync();
            for (int c = 0; c < 1500; c++) begin
                if ($urandom_range(0, 15) == 0) en_r = ~en_r;
                cur_sel  = 3'($urandom_range(0, 7));
                cur_grid = 1'($urandom_range(0, 1));
                drive(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 19) == 0),
                      en_r, 1'($urandom_range(0, 1)));
            end
        end
        idle(6);

        cur_test = "end";
        check("pops_min", 32'(n_pops >= 8000), 32'd1);
        check("queue_left", 32'(exp_q.size()), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
